gap_state_detect: RTL and testbench

- Parametrised successor to the single-window breakdown detector in the discharge_control path.
- Classifies the EDM gap during the wait-breakdown phase as normal breakdown, short circuit or open-gap timeout.
- Uses debounced sample windows with runtime-programmable thresholds, and measures ignition delay.
- Sits between the ADC sample path and the discharge state machine, which consumes the latched flags.

---
 rtl/gap_state_detect.sv | 199 +++++++++++++++++++
 tb/tb_gap_state_detect.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gap_state_detect.sv
// Gap state classifier for the wait-breakdown phase: debounced breakdown / short / open-gap
// timeout detection with latched flags, ignition delay capture and a breakdown event counter.
module gap_state_detect #(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned CNT_W         = 16,
    parameter bit          CUR_DETECT_EN = 1'b0,
    parameter int unsigned EVT_CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [DATA_W-1:0]    sample_current,
    input  logic signed [DATA_W-1:0]    sample_voltage,
    input  logic                        sample_valid,
    input  logic        [7:0]           current_state,
    input  logic signed [DATA_W-1:0]    thr_bd_vol,
    input  logic signed [DATA_W-1:0]    thr_short_vol,
    input  logic signed [DATA_W-1:0]    thr_cur,
    input  logic        [CNT_W-1:0]     confirm_cycles,
    input  logic        [CNT_W-1:0]     blank_cycles,
    input  logic        [CNT_W-1:0]     timeout_cycles,
    output logic                        is_breakdown,
    output logic                        is_short,
    output logic                        is_open_timeout,
    output logic        [CNT_W-1:0]     ignition_delay,
    output logic        [EVT_CNT_W-1:0] breakdown_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BLANK   = 2'd1,
        S_MONITOR = 2'd2,
        S_LATCHED = 2'd3
    } state_t;

    localparam logic [7:0]       ST_WAIT    = 8'h01;
    localparam logic [7:0]       ST_DEION_A = 8'h80;
    localparam logic [7:0]       ST_DEION_B = 8'h00;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    // Declaration vector bit positions: {breakdown, short, timeout}
    localparam logic [2:0] DECL_BD = 3'b100;
    localparam logic [2:0] DECL_SH = 3'b010;
    localparam logic [2:0] DECL_TO = 3'b001;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     wait_cnt, wait_d;
    logic [CNT_W-1:0]     vol_cnt, vol_d;
    logic [CNT_W-1:0]     short_cnt, short_d;
    logic [CNT_W-1:0]     cur_cnt, cur_d;
    logic                 bd_d, sh_d, to_d;
    logic [CNT_W-1:0]     delay_d;
    logic [EVT_CNT_W-1:0] count_d;

    logic             in_wait_c, deion_c;
    logic [CNT_W-1:0] confirm_c, wait_inc_c;
    logic             vol_win_c, vol_short_c, cur_ok_c;
    logic             timeout_hit_c, short_hit_c, bd_hit_c;
    logic [2:0]       decl_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Valid hit advances, valid miss clears, invalid sample holds.
    function automatic logic [CNT_W-1:0] debounce(input logic [CNT_W-1:0] v,
                                                   input logic valid, input logic hit);
        if (!valid) return v;
        return hit ? sat_inc(v) : '0;
    endfunction

    always_comb begin
        in_wait_c     = (current_state == ST_WAIT);
        deion_c       = (current_state == ST_DEION_A) || (current_state == ST_DEION_B);
        confirm_c     = (confirm_cycles == '0) ? CNT_W'(1) : confirm_cycles;
        wait_inc_c    = sat_inc(wait_cnt);
        vol_win_c     = (sample_voltage >= thr_short_vol) && (sample_voltage <= thr_bd_vol);
        vol_short_c   = (sample_voltage < thr_short_vol);
        cur_ok_c      = (sample_current >= thr_cur);
        timeout_hit_c = (timeout_cycles != '0) && (wait_cnt >= timeout_cycles);
        short_hit_c   = (short_cnt >= confirm_c);
        bd_hit_c      = (vol_cnt >= confirm_c) && (!CUR_DETECT_EN || (cur_cnt >= confirm_c));
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        wait_d  = wait_cnt;
        vol_d   = vol_cnt;
        short_d = short_cnt;
        cur_d   = cur_cnt;
        bd_d    = is_breakdown;
        sh_d    = is_short;
        to_d    = is_open_timeout;
        delay_d = ignition_delay;
        count_d = breakdown_count;
        decl_c  = 3'b000;

        if (deion_c) begin
            state_d = S_IDLE;
            wait_d  = '0;
            vol_d   = '0;
            short_d = '0;
            cur_d   = '0;
            bd_d    = 1'b0;
            sh_d    = 1'b0;
            to_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_wait_c) begin
                        state_d = S_BLANK;
                        wait_d  = '0;
                        vol_d   = '0;
                        short_d = '0;
                        cur_d   = '0;
                    end
                end
                S_BLANK: begin
                    if (!in_wait_c) begin
                        state_d = S_IDLE;
                        wait_d  = '0;
                        vol_d   = '0;
                        short_d = '0;
                        cur_d   = '0;
                    end else if (timeout_hit_c) begin
                        decl_c = DECL_TO;
                    end else begin
                        wait_d  = wait_inc_c;
                        vol_d   = '0;
                        short_d = '0;
                        cur_d   = '0;
                        if (wait_cnt >= blank_cycles) state_d = S_MONITOR;
                    end
                end
                S_MONITOR: begin
                    if (!in_wait_c) begin
                        state_d = S_IDLE;
                        wait_d  = '0;
                        vol_d   = '0;
                        short_d = '0;
                        cur_d   = '0;
                    end else if (short_hit_c) begin
                        decl_c = DECL_SH;
                    end else if (bd_hit_c) begin
                        decl_c = DECL_BD;
                    end else if (timeout_hit_c) begin
                        decl_c = DECL_TO;
                    end else begin
                        wait_d  = wait_inc_c;
                        vol_d   = debounce(vol_cnt, sample_valid, vol_win_c);
                        short_d = debounce(short_cnt, sample_valid, vol_short_c);
                        cur_d   = debounce(cur_cnt, sample_valid, cur_ok_c);
                    end
                end
                S_LATCHED: begin
                    state_d = S_LATCHED;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // One-hot flag set so a stale flag from an aborted window cannot coexist
            if (decl_c != 3'b000) begin
                {bd_d, sh_d, to_d} = decl_c;
                delay_d            = wait_cnt;
                state_d            = S_LATCHED;
                if (decl_c[2]) count_d = breakdown_count + EVT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            wait_cnt        <= '0;
            vol_cnt         <= '0;
            short_cnt       <= '0;
            cur_cnt         <= '0;
            is_breakdown    <= 1'b0;
            is_short        <= 1'b0;
            is_open_timeout <= 1'b0;
            ignition_delay  <= '0;
            breakdown_count <= '0;
        end else begin
            state_q         <= state_d;
            wait_cnt        <= wait_d;
            vol_cnt         <= vol_d;
            short_cnt       <= short_d;
            cur_cnt         <= cur_d;
            is_breakdown    <= bd_d;
            is_short        <= sh_d;
            is_open_timeout <= to_d;
            ignition_delay  <= delay_d;
            breakdown_count <= count_d;
        end
    end

endmodule

// File: tb/tb_gap_state_detect.sv
// Directed bench for gap_state_detect: two instances (voltage-only and current-qualified)
// share stimulus; expected events are queued per instance and checked when flags rise.
module tb_gap_state_detect;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned EVT_CNT_W = 16;

    localparam logic [2:0] F_BD = 3'b100;
    localparam logic [2:0] F_SH = 3'b010;
    localparam logic [2:0] F_TO = 3'b001;

    logic                        clk;
    logic                        rst_n;
    logic signed [DATA_W-1:0]    sample_current;
    logic signed [DATA_W-1:0]    sample_voltage;
    logic                        sample_valid;
    logic        [7:0]           current_state;
    logic signed [DATA_W-1:0]    thr_bd_vol;
    logic signed [DATA_W-1:0]    thr_short_vol;
    logic signed [DATA_W-1:0]    thr_cur;
    logic        [CNT_W-1:0]     confirm_cycles;
    logic        [CNT_W-1:0]     blank_cycles;
    logic        [CNT_W-1:0]     timeout_cycles;

    logic                 bd0, sh0, to0, bd1, sh1, to1;
    logic [CNT_W-1:0]     dl0, dl1;
    logic [EVT_CNT_W-1:0] bc0, bc1;
    logic [2:0]           fl0, fl1;

    assign fl0 = {bd0, sh0, to0};
    assign fl1 = {bd1, sh1, to1};

    gap_state_detect #(.DATA_W(DATA_W), .CNT_W(CNT_W), .CUR_DETECT_EN(1'b0), .EVT_CNT_W(EVT_CNT_W)) dut0 (
        .clk(clk), .rst_n(rst_n), .sample_current(sample_current), .sample_voltage(sample_voltage),
        .sample_valid(sample_valid), .current_state(current_state), .thr_bd_vol(thr_bd_vol),
        .thr_short_vol(thr_short_vol), .thr_cur(thr_cur), .confirm_cycles(confirm_cycles),
        .blank_cycles(blank_cycles), .timeout_cycles(timeout_cycles), .is_breakdown(bd0),
        .is_short(sh0), .is_open_timeout(to0), .ignition_delay(dl0), .breakdown_count(bc0));

    gap_state_detect #(.DATA_W(DATA_W), .CNT_W(CNT_W), .CUR_DETECT_EN(1'b1), .EVT_CNT_W(EVT_CNT_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_current(sample_current), .sample_voltage(sample_voltage),
        .sample_valid(sample_valid), .current_state(current_state), .thr_bd_vol(thr_bd_vol),
        .thr_short_vol(thr_short_vol), .thr_cur(thr_cur), .confirm_cycles(confirm_cycles),
        .blank_cycles(blank_cycles), .timeout_cycles(timeout_cycles), .is_breakdown(bd1),
        .is_short(sh1), .is_open_timeout(to1), .ignition_delay(dl1), .breakdown_count(bc1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [2:0] flags;
        int         delay;
        int         count;
        int         edge_n;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    int         n_asserts = 0;
    int         n_fail    = 0;
    int         edge_cnt  = 0;
    logic [2:0] prev0     = 3'b000;
    logic [2:0] prev1     = 3'b000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int d, input string tag, input logic [2:0] f,
                        input int dly, input int cnt, input int e);
        exp_t x;
        x.tag = tag; x.flags = f; x.delay = dly; x.count = cnt; x.edge_n = e;
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    // On a flag rising edge, pop the expected event for that instance and compare.
    task automatic score(input int d);
        logic [2:0]           now;
        logic [2:0]           prev;
        logic [CNT_W-1:0]     dl;
        logic [EVT_CNT_W-1:0] bc;
        int                   sz;
        exp_t                 e;
        now  = (d == 0) ? fl0 : fl1;
        prev = (d == 0) ? prev0 : prev1;
        dl   = (d == 0) ? dl0 : dl1;
        bc   = (d == 0) ? bc0 : bc1;
        sz   = (d == 0) ? q0.size() : q1.size();
        if (prev == 3'b000 && now != 3'b000) begin
            chk($sformatf("dut%0d event_expected edge%0d", d, edge_cnt), 32'(sz != 0), 32'd1);
            if (sz != 0) begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk({e.tag, " flags"}, 32'(now), 32'(e.flags));
                chk({e.tag, " ignition_delay"}, 32'(dl), 32'(e.delay));
                chk({e.tag, " breakdown_count"}, 32'(bc), 32'(e.count));
                chk({e.tag, " edge"}, 32'(edge_cnt), 32'(e.edge_n));
            end
        end
        if (d == 0) prev0 = now;
        else        prev1 = now;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            edge_cnt++;
            #1;
            score(0);
            score(1);
        end
    endtask

    task automatic drained(input string tag);
        chk({tag, " dut0 queue drained"}, 32'(q0.size()), 32'd0);
        chk({tag, " dut1 queue drained"}, 32'(q1.size()), 32'd0);
    endtask

    task automatic deion();
        current_state = 8'h80;
        step(2);
    endtask

    task automatic enter_wait();
        current_state = 8'h01;
        step(1);
        edge_cnt = 0;
    endtask

    initial begin
        rst_n          = 1'b0;
        sample_current = '0;
        sample_voltage = '0;
        sample_valid   = 1'b1;
        current_state  = 8'h80;
        thr_bd_vol     = 16'sd35;
        thr_short_vol  = 16'sd8;
        thr_cur        = 16'sd10;
        confirm_cycles = 16'd10;
        blank_cycles   = 16'd400;
        timeout_cycles = 16'd0;

        #1;
        chk("reset flags0", 32'(fl0), 32'd0);
        chk("reset delay0", 32'(dl0), 32'd0);
        chk("reset count0", 32'(bc0), 32'd0);
        chk("reset flags1", 32'(fl1), 32'd0);
        step(3);
        rst_n = 1'b1;
        step(2);

        // Normal breakdown after blanking, voltage-only qualification
        sample_voltage = 16'sd20;
        push(0, "bd_basic", F_BD, 411, 1, 412);
        enter_wait();
        step(420);
        drained("bd_basic");
        current_state = 8'h05;
        step(2);
        current_state = 8'h01;
        step(5);
        chk("latched hold flags", 32'(fl0), 32'(F_BD));
        chk("latched hold delay", 32'(dl0), 32'd411);
        deion();
        chk("deion clears bd", 32'(fl0), 32'd0);
        chk("deion holds delay", 32'(dl0), 32'd411);
        chk("deion holds count", 32'(bc0), 32'd1);

        // Short circuit; DEION clears the flag on the next clock
        sample_voltage = 16'sd3;
        push(0, "short0", F_SH, 411, 1, 412);
        push(1, "short1", F_SH, 411, 0, 412);
        enter_wait();
        step(420);
        drained("short");
        current_state = 8'h80;
        step(1);
        chk("short cleared", 32'(fl0), 32'd0);
        chk("short count unchanged", 32'(bc0), 32'd1);
        step(1);

        // Open-gap timeout, then disabled timeout with wait counter saturation
        sample_voltage = 16'sd90;
        timeout_cycles = 16'd1000;
        push(0, "timeout0", F_TO, 1000, 1, 1001);
        push(1, "timeout1", F_TO, 1000, 0, 1001);
        enter_wait();
        step(1010);
        drained("timeout");
        deion();
        timeout_cycles = 16'd0;
        enter_wait();
        step(70000);
        chk("no timeout when disabled0", 32'(fl0), 32'd0);
        chk("no timeout when disabled1", 32'(fl1), 32'd0);
        deion();

        // Current-qualified breakdown waits for I to cross thr_cur
        blank_cycles   = 16'd0;
        sample_voltage = 16'sd20;
        sample_current = 16'sd5;
        push(0, "cur_off_bd", F_BD, 11, 2, 12);
        push(1, "cur_on_bd", F_BD, 61, 1, 62);
        enter_wait();
        step(51);
        sample_current = 16'sd12;
        step(20);
        drained("cur");
        deion();
        sample_current = 16'sd0;

        // confirm_cycles=0 behaves as 1
        confirm_cycles = 16'd0;
        push(0, "confirm0", F_BD, 2, 3, 3);
        enter_wait();
        step(10);
        drained("confirm0");
        deion();
        confirm_cycles = 16'd10;

        // Debounce holds across invalid clocks
        push(0, "valid_hold", F_BD, 20, 4, 21);
        enter_wait();
        for (int k = 0; k < 30; k++) begin
            sample_valid = ((edge_cnt + 1) % 2) == 0;
            step(1);
        end
        drained("valid_hold");
        deion();

        // Window toggling every 5 valid samples never confirms
        enter_wait();
        for (int k = 0; k < 200; k++) begin
            sample_valid   = ((edge_cnt + 1) % 2) == 0;
            sample_voltage = ((((edge_cnt + 1) / 10) % 2) != 0) ? 16'sd50 : 16'sd20;
            step(1);
        end
        chk("toggle no event0", 32'(fl0), 32'd0);
        chk("toggle no event1", 32'(fl1), 32'd0);
        chk("toggle count held", 32'(bc0), 32'd4);
        deion();
        sample_valid   = 1'b1;
        sample_voltage = 16'sd20;

        // Asynchronous reset mid-window, then wait in IDLE for the next WAIT entry
        enter_wait();
        step(8);
        rst_n = 1'b0;
        #1;
        chk("async rst flags0", 32'(fl0), 32'd0);
        chk("async rst count0", 32'(bc0), 32'd0);
        chk("async rst delay0", 32'(dl0), 32'd0);
        chk("async rst count1", 32'(bc1), 32'd0);
        chk("async rst delay1", 32'(dl1), 32'd0);
        current_state = 8'h02;
        rst_n         = 1'b1;
        prev0         = fl0;
        prev1         = fl1;
        step(50);
        chk("idle after reset", 32'(fl0), 32'd0);
        push(0, "post_reset_bd", F_BD, 11, 1, 12);
        enter_wait();
        step(20);
        drained("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
